conf_merge_arb4: RTL and testbench

//  Synchronous 4-channel collector in front of the drive/free mutex-merge stage.

---
 rtl/conf_merge_arb4.sv | 155 +++++++++++++++
 tb/tb_conf_merge_arb4.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/conf_merge_arb4.sv
// Four-channel token collector: buffers one token per source, arbitrates round-robin,
// and keeps at most one token outstanding on the drive/free handshake downstream.
module conf_merge_arb4 #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            i_drive,
    input  logic [4*DATA_W-1:0]   i_data,
    output logic [3:0]            o_free,
    output logic                  o_driveNext,
    output logic [DATA_W-1:0]     o_dataNext,
    output logic [1:0]            o_srcNext,
    input  logic                  i_freeNext,
    output logic                  o_err,
    output logic                  o_timeout
);

    localparam int                CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [3:0]        pending_q, pending_d;
    logic [1:0]        rr_last_q, rr_last_d;
    logic              drive_q, drive_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        src_q, src_d;
    logic [3:0]        free_q, free_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;

    logic [DATA_W-1:0] payload_q [4];
    logic [3:0]        payload_we;
    logic [3:0]        req;
    logic [1:0]        grant;
    logic              free_ok;

    // Search order begins one past the last grant; earliest hit in that order wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign req     = pending_q | i_drive;
    assign grant   = rr_pick(req, rr_last_q);
    // A free arriving in the launch cycle itself is treated as a stray free.
    assign free_ok = (state_q == ST_WAIT) && i_freeNext && !drive_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        rr_last_d  = rr_last_q;
        drive_d    = 1'b0;
        data_d     = data_q;
        src_d      = src_q;
        free_d     = 4'b0000;
        err_d      = err_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q;
        payload_we = 4'b0000;

        for (int k = 0; k < 4; k++) begin
            if (i_drive[k]) begin
                if (pending_q[k]) begin
                    err_d = 1'b1;
                end else begin
                    pending_d[k]  = 1'b1;
                    payload_we[k] = 1'b1;
                end
            end
        end

        if (i_freeNext && !free_ok) err_d = 1'b1;

        if (state_q == ST_IDLE && req != 4'b0000) begin
            drive_d   = 1'b1;
            src_d     = grant;
            rr_last_d = grant;
            state_d   = ST_WAIT;
            for (int k = 0; k < 4; k++) begin
                if (grant == 2'(k)) begin
                    data_d = pending_q[k] ? payload_q[k] : i_data[k*DATA_W +: DATA_W];
                end
            end
        end

        if (free_ok) begin
            pending_d[src_q] = 1'b0;
            free_d[src_q]    = 1'b1;
            state_d          = ST_IDLE;
        end

        // Watchdog only flags a stuck token; the handshake keeps waiting.
        if (TIMEOUT > 0 && state_q == ST_WAIT) begin
            cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (cnt_inc == CNT_MAX) tmo_d = 1'b1;
            cnt_d = free_ok ? '0 : cnt_inc;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            rr_last_q <= 2'd3;
            drive_q   <= 1'b0;
            data_q    <= '0;
            src_q     <= 2'd0;
            free_q    <= 4'b0000;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_last_q <= rr_last_d;
            drive_q   <= drive_d;
            data_q    <= data_d;
            src_q     <= src_d;
            free_q    <= free_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (payload_we[k]) payload_q[k] <= i_data[k*DATA_W +: DATA_W];
        end
    end

    assign o_free      = free_q;
    assign o_driveNext = drive_q;
    assign o_dataNext  = data_q;
    assign o_srcNext   = src_q;
    assign o_err       = err_q;
    assign o_timeout   = tmo_q;

endmodule

// File: tb/tb_conf_merge_arb4.sv
// Scoreboard bench for conf_merge_arb4: expected launches are queued when tokens are driven.
module tb_conf_merge_arb4;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [3:0]          i_drive = 4'b0000;
    logic [4*DATA_W-1:0] i_data = '0;
    logic                i_freeNext = 1'b0;
    logic [3:0]          o_free;
    logic                o_driveNext;
    logic [DATA_W-1:0]   o_dataNext;
    logic [1:0]          o_srcNext;
    logic                o_err;
    logic                o_timeout;

    conf_merge_arb4 #(.DATA_W(DATA_W), .TIMEOUT(5)) dut (
        .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data),
        .o_free(o_free), .o_driveNext(o_driveNext), .o_dataNext(o_dataNext),
        .o_srcNext(o_srcNext), .i_freeNext(i_freeNext), .o_err(o_err), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
    } tok_t;

    tok_t       exp_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         launch_cnt = 0;
    int         free_cnt = 0;
    logic       drv_prev = 1'b0;
    logic [1:0] last_src = 2'd0;
    logic [7:0] last_data = 8'h00;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; i_drive = 4'b0000; i_freeNext = 1'b0; i_data = '0;
        tick;
        tick;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_pulse(input logic [3:0] mask, input logic [31:0] data);
        i_drive = mask;
        i_data  = data;
        tick;
        i_drive = 4'b0000;
    endtask

    task automatic expect_launch(input int max_cyc);
        tok_t e;
        bit   seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            if (o_driveNext) seen = 1'b1;
        end
        if (!seen) begin
            chk_eq("launch_timeout", {31'd0, seen}, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk_eq("launch_unexpected", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk_eq("launch_src", o_srcNext, e.src);
        chk_eq("launch_data", o_dataNext, e.data);
        last_src  = e.src;
        last_data = e.data;
    endtask

    task automatic do_free(input int delay);
        logic [3:0] m;
        repeat (delay) tick;
        chk_eq("data_hold", o_dataNext, last_data);
        i_freeNext = 1'b1;
        tick;
        i_freeNext = 1'b0;
        @(negedge clk);
        m = 4'b0001 << last_src;
        chk_eq("free_pulse", o_free, m);
    endtask

    // Running invariants on every sampled cycle.
    always @(negedge clk) begin
        if (o_driveNext) begin
            launch_cnt++;
            chk_eq("drive_consec", drv_prev, 0);
        end
        drv_prev = o_driveNext;
        if (o_free != 4'b0000) begin
            free_cnt++;
            chk_eq("free_onehot", $onehot0(o_free), 1);
        end
    end

    initial begin
        int f0, l0;
        logic [7:0] d;

        // Reset and first launch latency
        do_reset;
        @(negedge clk);
        chk_eq("rst_drive", o_driveNext, 0);
        chk_eq("rst_free", o_free, 0);
        chk_eq("rst_data", o_dataNext, 0);
        chk_eq("rst_src", o_srcNext, 0);
        chk_eq("rst_err", o_err, 0);
        chk_eq("rst_timeout", o_timeout, 0);
        exp_q.push_back(tok_t'{2'd0, 8'hA5});
        drive_pulse(4'b0001, 32'h0000_00A5);
        expect_launch(1);
        do_free(3);
        chk_eq("t1_err", o_err, 0);

        // All four channels at once
        do_reset;
        for (int k = 0; k < 4; k++) exp_q.push_back(tok_t'{2'(k), 8'(8'h10 + k)});
        drive_pulse(4'b1111, 32'h1312_1110);
        for (int k = 0; k < 4; k++) begin
            expect_launch(4);
            do_free(3);
        end
        chk_eq("t2_err", o_err, 0);

        // Fairness between ch0 and ch2
        do_reset;
        exp_q.push_back(tok_t'{2'd0, 8'h20});
        exp_q.push_back(tok_t'{2'd2, 8'h40});
        drive_pulse(4'b0101, 32'h0040_0020);
        for (int g = 0; g < 16; g++) begin
            expect_launch(4);
            do_free(1);
            if (g < 14) begin
                d = ((last_src == 2'd0) ? 8'h20 : 8'h40) + 8'(g + 1);
                exp_q.push_back(tok_t'{last_src, d});
                drive_pulse(4'b0001 << last_src, 32'(d) << (8 * last_src));
            end
        end
        chk_eq("t3_err", o_err, 0);

        // Overrun on ch1
        do_reset;
        f0 = free_cnt;
        l0 = launch_cnt;
        exp_q.push_back(tok_t'{2'd1, 8'h55});
        drive_pulse(4'b0010, 32'h0000_5500);
        expect_launch(1);
        drive_pulse(4'b0010, 32'h0000_6600);
        @(negedge clk);
        chk_eq("ovr_err", o_err, 1);
        do_free(2);
        repeat (5) tick;
        chk_eq("ovr_free_cnt", 32'(free_cnt - f0), 1);
        chk_eq("ovr_launch_cnt", 32'(launch_cnt - l0), 1);

        // Stray free while idle
        do_reset;
        i_freeNext = 1'b1;
        tick;
        i_freeNext = 1'b0;
        @(negedge clk);
        chk_eq("stray_err", o_err, 1);
        chk_eq("stray_free", o_free, 0);
        chk_eq("stray_drive", o_driveNext, 0);
        exp_q.push_back(tok_t'{2'd3, 8'h77});
        drive_pulse(4'b1000, 32'h7700_0000);
        expect_launch(1);
        do_free(1);

        // Watchdog, late free, then reset mid-wait
        do_reset;
        exp_q.push_back(tok_t'{2'd2, 8'h99});
        drive_pulse(4'b0100, 32'h0099_0000);
        expect_launch(1);
        for (int c = 1; c <= 4; c++) begin
            tick;
            @(negedge clk);
            chk_eq("tmo_early", o_timeout, 0);
        end
        tick;
        @(negedge clk);
        chk_eq("tmo_set", o_timeout, 1);
        do_free(2);
        chk_eq("tmo_sticky", o_timeout, 1);
        chk_eq("tmo_err", o_err, 0);
        chk_eq("queue_empty", 32'(exp_q.size()), 0);

        exp_q.push_back(tok_t'{2'd0, 8'hC3});
        drive_pulse(4'b0001, 32'h0000_00C3);
        expect_launch(1);
        tick;
        tick;
        f0 = free_cnt;
        do_reset;
        repeat (4) tick;
        @(negedge clk);
        chk_eq("rst2_drive", o_driveNext, 0);
        chk_eq("rst2_free", o_free, 0);
        chk_eq("rst2_timeout", o_timeout, 0);
        chk_eq("rst2_err", o_err, 0);
        tick;
        chk_eq("rst2_free_cnt", 32'(free_cnt - f0), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1);
    end

endmodule
